forward_multi_stable_cdc: RTL and testbench

Next-generation multi-bit forward synchronizer for quasi-static status and configuration words crossing into the `clk` domain. Each bit passes through a configurable-depth flip-flop synchronizer. The synchronized word is committed to `dataStable` only after it has held unchanged for a programmable number of cycles, so every committed value is coherent across bits. A one-cycle update strobe, per-bit edge pulses and a saturating glitch counter of abandoned transitions are also provided.

---
 rtl/forward_multi_stable_cdc.sv | 81 ++++++++
 tb/tb_forward_multi_stable_cdc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_multi_stable_cdc.sv
// Multi-bit forward synchronizer: per-bit flop chain, then a stability window that commits
// only coherent words, with commit edge pulses and a saturating count of abandoned values.
module forward_multi_stable_cdc #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   dataIn,
  input  logic                    glitchClear,
  output logic [DATA_WIDTH-1:0]   dataSync,
  output logic [DATA_WIDTH-1:0]   dataStable,
  output logic                    dataValid,
  output logic [DATA_WIDTH-1:0]   riseEdge,
  output logic [DATA_WIDTH-1:0]   fallEdge,
  output logic [GLITCH_WIDTH-1:0] glitchCount
);
  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] r);
    return (r >= RUN_MAX) ? RUN_MAX : RUN_W'(r + 1'b1);
  endfunction

  function automatic logic [GLITCH_WIDTH-1:0] glitch_sat_inc(input logic [GLITCH_WIDTH-1:0] c);
    return (&c) ? c : GLITCH_WIDTH'(c + 1'b1);
  endfunction

  logic [DATA_WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_prev_p1;
  logic [RUN_W-1:0]      run_p1;
  logic [RUN_W-1:0]      run_cur;
  logic                  chg;
  logic                  commit;
  logic                  abandon;

  // Synchronizer chain: stage 0 is the only flop that sees the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= dataIn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign dataSync = sync_p[SYNC_STAGES-1];
  assign chg      = (dataSync != sync_prev_p1);
  assign run_cur  = chg ? RUN_W'(1) : run_sat_inc(run_p1);
  assign commit   = (dataSync != dataStable) && (run_cur == RUN_MAX);
  assign abandon  = chg && (sync_prev_p1 != dataStable);

  // Qualification stage: run length, commit, edge pulses and glitch count
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_prev_p1 <= '0;
      run_p1       <= '0;
      dataStable   <= '0;
      dataValid    <= 1'b0;
      riseEdge     <= '0;
      fallEdge     <= '0;
      glitchCount  <= '0;
    end else begin
      sync_prev_p1 <= dataSync;
      run_p1       <= run_cur;
      dataValid    <= commit;
      if (commit) begin
        dataStable <= dataSync;
        riseEdge   <= dataSync & ~dataStable;
        fallEdge   <= ~dataSync & dataStable;
      end else begin
        riseEdge   <= '0;
        fallEdge   <= '0;
      end
      if (glitchClear)  glitchCount <= '0;
      else if (abandon) glitchCount <= glitch_sat_inc(glitchCount);
    end
  end
endmodule

// File: tb/tb_forward_multi_stable_cdc.sv
// Bench for forward_multi_stable_cdc: three configurations checked each cycle against a
// history-window model, plus directed literal checks of the key scenarios.
module tb_forward_multi_stable_cdc;
  logic       clk = 1'b0;
  logic [7:0] din   [3];
  logic       rst_v [3];
  logic       clr   [3];
  logic [7:0] dsync [3];
  logic [7:0] dstab [3];
  logic       vld   [3];
  logic [7:0] rise  [3];
  logic [7:0] fall  [3];
  logic [15:0] gc0, gc2;
  logic [3:0]  gc1;

  int total = 0;
  int bad   = 0;
  int vcnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  forward_multi_stable_cdc #(.DATA_WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_WIDTH(16)) u0 (
    .clk(clk), .rst(rst_v[0]), .dataIn(din[0]), .glitchClear(clr[0]), .dataSync(dsync[0]),
    .dataStable(dstab[0]), .dataValid(vld[0]), .riseEdge(rise[0]), .fallEdge(fall[0]), .glitchCount(gc0));
  forward_multi_stable_cdc #(.DATA_WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_WIDTH(4)) u1 (
    .clk(clk), .rst(rst_v[1]), .dataIn(din[1]), .glitchClear(clr[1]), .dataSync(dsync[1]),
    .dataStable(dstab[1]), .dataValid(vld[1]), .riseEdge(rise[1]), .fallEdge(fall[1]), .glitchCount(gc1));
  forward_multi_stable_cdc #(.DATA_WIDTH(8), .SYNC_STAGES(3), .STABLE_CYCLES(1), .GLITCH_WIDTH(16)) u2 (
    .clk(clk), .rst(rst_v[2]), .dataIn(din[2]), .glitchClear(clr[2]), .dataSync(dsync[2]),
    .dataStable(dstab[2]), .dataValid(vld[2]), .riseEdge(rise[2]), .fallEdge(fall[2]), .glitchCount(gc2));

  // Model: input history and dataSync history per instance
  int         s_of [3] = '{2, 2, 3};
  int         n_of [3] = '{4, 4, 1};
  int         gmax [3] = '{65535, 15, 65535};
  logic [7:0] ih [3][8];
  logic [7:0] sh [3][8];
  logic [7:0] m_stab [3];
  logic [7:0] m_rise [3];
  logic [7:0] m_fall [3];
  logic       m_vld  [3];
  int         m_gc   [3];
  bit         mvalid [3] = '{0, 0, 0};

  task automatic model_step(input int id);
    bit         held;
    bit         abandon;
    logic [7:0] cur;
    if (rst_v[id]) begin
      for (int k = 0; k < 8; k++) begin
        ih[id][k] = 8'h00;
        sh[id][k] = 8'h00;
      end
      m_stab[id] = 8'h00; m_rise[id] = 8'h00; m_fall[id] = 8'h00;
      m_vld[id]  = 1'b0;  m_gc[id]   = 0;     mvalid[id] = 1'b1;
    end else begin
      cur  = sh[id][0];
      held = 1'b1;
      for (int k = 1; k < n_of[id]; k++) if (sh[id][k] != cur) held = 1'b0;
      abandon = (sh[id][0] != sh[id][1]) && (sh[id][1] != m_stab[id]);
      if (clr[id]) m_gc[id] = 0;
      else if (abandon && m_gc[id] < gmax[id]) m_gc[id] = m_gc[id] + 1;
      if (held && cur != m_stab[id]) begin
        m_rise[id] = cur & ~m_stab[id];
        m_fall[id] = ~cur & m_stab[id];
        m_stab[id] = cur;
        m_vld[id]  = 1'b1;
      end else begin
        m_rise[id] = 8'h00; m_fall[id] = 8'h00; m_vld[id] = 1'b0;
      end
      for (int k = 7; k > 0; k--) ih[id][k] = ih[id][k-1];
      ih[id][0] = din[id];
      for (int k = 7; k > 0; k--) sh[id][k] = sh[id][k-1];
      sh[id][0] = ih[id][s_of[id]-1];
    end
  endtask

  always @(posedge clk) for (int id = 0; id < 3; id++) model_step(id);

  function automatic logic [15:0] act_gc(input int id);
    case (id)
      0:       return gc0;
      1:       return {12'h000, gc1};
      default: return gc2;
    endcase
  endfunction

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d actual=%0h required=%0h t=%0t", nm, id, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int id = 0; id < 3; id++) begin
      if (mvalid[id]) begin
        check("dataSync",    id, dsync[id],  sh[id][0]);
        check("dataStable",  id, dstab[id],  m_stab[id]);
        check("dataValid",   id, vld[id],    m_vld[id]);
        check("riseEdge",    id, rise[id],   m_rise[id]);
        check("fallEdge",    id, fall[id],   m_fall[id]);
        check("glitchCount", id, act_gc(id), m_gc[id]);
        if (vld[id] === 1'b1) vcnt[id]++;
      end
    end
  end

  int hold [3] = '{0, 0, 0};
  int v0;

  initial begin
    for (int id = 0; id < 3; id++) begin
      din[id] = 8'h00; rst_v[id] = 1'b1; clr[id] = 1'b0;
    end
    // Reset idle
    repeat (3) @(negedge clk);
    for (int id = 0; id < 3; id++) rst_v[id] = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_vcnt", 0, vcnt[0], 0);
    check("idle_stable", 0, dstab[0], 8'h00);
    check("idle_gc", 0, gc0, 0);

    // Clean step 0x00 -> 0xA5
    din[0] = 8'hA5;
    repeat (2) @(posedge clk); #1;
    check("step_sync_E1", 0, dsync[0], 8'hA5);
    repeat (3) @(posedge clk); #1;
    check("step_stable_E4", 0, dstab[0], 8'h00);
    @(posedge clk); #1;
    check("step_stable_E5", 0, dstab[0], 8'hA5);
    check("step_valid", 0, vld[0], 1'b1);
    check("step_rise", 0, rise[0], 8'hA5);
    check("step_fall", 0, fall[0], 8'h00);
    check("model_stable", 0, m_stab[0], 8'hA5);
    @(posedge clk); #1;
    check("step_valid_off", 0, vld[0], 1'b0);
    repeat (6) @(negedge clk);
    check("step_one_pulse", 0, vcnt[0], 1);

    // Follow-up 0xA5 -> 0x5A
    din[0] = 8'h5A;
    repeat (6) @(posedge clk); #1;
    check("step2_stable", 0, dstab[0], 8'h5A);
    check("step2_rise", 0, rise[0], 8'h5A);
    check("step2_fall", 0, fall[0], 8'hA5);
    @(negedge clk) din[0] = 8'h00;
    repeat (10) @(negedge clk);

    // Glitch rejection from committed 0x00
    v0 = vcnt[0];
    din[0] = 8'h3C;
    repeat (2) @(negedge clk);
    din[0] = 8'h00;
    repeat (10) @(negedge clk);
    check("glitch_stable", 0, dstab[0], 8'h00);
    check("glitch_novalid", 0, vcnt[0], v0);
    check("glitch_count1", 0, gc0, 1);
    check("model_gc1", 0, m_gc[0], 1);
    din[0] = 8'h11; @(negedge clk);
    din[0] = 8'h22; @(negedge clk);
    din[0] = 8'h00;
    repeat (10) @(negedge clk);
    check("glitch_count3", 0, gc0, 3);

    // Saturation on the 4-bit counter
    for (int g = 0; g < 20; g++) begin
      din[1] = 8'h3C; repeat (2) @(negedge clk);
      din[1] = 8'h00; repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("sat_count15", 1, gc1, 4'hF);
    // Clear on the same edge as a further increment
    din[1] = 8'h3C; repeat (2) @(negedge clk);
    din[1] = 8'h00; repeat (2) @(negedge clk);
    clr[1] = 1'b1;
    @(posedge clk); #1;
    check("clear_wins", 1, gc1, 4'h0);
    @(negedge clk) clr[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("clear_holds", 1, gc1, 4'h0);

    // Reset while a value is pending
    din[0] = 8'hFF;
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    check("rstmid_sync", 0, dsync[0], 8'h00);
    check("rstmid_stable", 0, dstab[0], 8'h00);
    check("rstmid_valid", 0, vld[0], 1'b0);
    check("rstmid_gc", 0, gc0, 0);
    @(negedge clk) rst_v[0] = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("rstmid_pre", 0, dstab[0], 8'h00);
    @(posedge clk); #1;
    check("rstmid_commit", 0, dstab[0], 8'hFF);
    check("rstmid_rise", 0, rise[0], 8'hFF);
    check("rstmid_vld", 0, vld[0], 1'b1);

    // N=1, three sync stages
    @(negedge clk) din[2] = 8'h04;
    repeat (3) @(posedge clk); #1;
    check("n1_pre", 2, dstab[2], 8'h00);
    @(posedge clk); #1;
    check("n1_commit", 2, dstab[2], 8'h04);
    check("n1_valid", 2, vld[2], 1'b1);
    @(negedge clk);
    for (int t = 0; t < 12; t++) begin
      din[2] = (t % 2 == 0) ? 8'h01 : 8'h02;
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("n1_final", 2, dstab[2], 8'h02);
    check("n1_gc", 2, gc2, 0);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int id = 0; id < 3; id++) begin
        if (hold[id] == 0) begin
          case ($urandom_range(0, 3))
            0:       din[id] = 8'($urandom);
            1:       din[id] = din[id] ^ (8'h01 << $urandom_range(0, 7));
            2:       din[id] = 8'h00;
            default: din[id] = 8'hA5;
          endcase
          hold[id] = $urandom_range(1, 7);
        end
        hold[id]--;
        clr[id]   = ($urandom_range(0, 40) == 0);
        rst_v[id] = ($urandom_range(0, 300) == 0);
      end
    end
    @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      clr[id] = 1'b0; rst_v[id] = 1'b0;
    end
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
